// File: rtl/writeback_stage_if.sv
// Bundle of execute-side handshake, data-memory bus and register-bank write-back
// signals for writeback_stage. WB_FWD_EN adds the forwarding outputs.
interface writeback_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] IR_ex;
    logic [31:0] ALU_ex;
    logic [31:0] B_ex;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] LMD;
    logic [4:0]  rd_w;
    logic        wb_en;
`ifdef WB_FWD_EN
    logic        fwd_busy;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    modport master (
        input  ex_valid, IR_ex, ALU_ex, B_ex, dmem_gnt, dmem_rvalid, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, LMD, rd_w, wb_en,
        output fwd_busy, fwd_rd, fwd_data
    );
    modport slave (
        output ex_valid, IR_ex, ALU_ex, B_ex, dmem_gnt, dmem_rvalid, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, LMD, rd_w, wb_en,
        input  fwd_busy, fwd_rd, fwd_data
    );
`else
    modport master (
        input  ex_valid, IR_ex, ALU_ex, B_ex, dmem_gnt, dmem_rvalid, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, LMD, rd_w, wb_en
    );
    modport slave (
        output ex_valid, IR_ex, ALU_ex, B_ex, dmem_gnt, dmem_rvalid, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, LMD, rd_w, wb_en
    );
`endif
endinterface

// File: rtl/writeback_stage.sv
// Memory/write-back stage: retires ALU results, issues load/store requests and
// strobes the register bank. Optional macro WB_FWD_EN adds forwarding outputs.
module writeback_stage #(
    parameter logic [5:0] OP_LW = 6'h23,
    parameter logic [5:0] OP_SW = 6'h2B
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;
    typedef enum logic [1:0] {K_NONE, K_ALU, K_LOAD, K_STORE} kind_e;

    function automatic kind_e classify(input logic [5:0] op);
        if (op == OP_LW)                              return K_LOAD;
        else if (op == OP_SW)                         return K_STORE;
        else if (op == 6'h00 || op[5:3] == 3'b001)    return K_ALU;
        else                                          return K_NONE;
    endfunction

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d, kind_in;
    logic [31:0] ir_q, ir_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] b_q, b_d;
    logic [31:0] lmd_q, lmd_d;
    logic [4:0]  rdw_q, rdw_d;

    assign kind_in = classify(bus.IR_ex[31:26]);

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        ir_d    = ir_q;
        alu_d   = alu_q;
        b_d     = b_q;
        lmd_d   = lmd_q;
        rdw_d   = rdw_q;
        case (state_q)
            IDLE: if (bus.ex_valid) begin
                ir_d   = bus.IR_ex;
                alu_d  = bus.ALU_ex;
                b_d    = bus.B_ex;
                kind_d = kind_in;
                case (kind_in)
                    K_ALU: begin
                        rdw_d   = bus.IR_ex[25:21];
                        lmd_d   = bus.ALU_ex;
                        state_d = WB;
                    end
                    K_LOAD: begin
                        rdw_d   = bus.IR_ex[25:21];
                        state_d = REQ;
                    end
                    K_STORE: state_d = REQ;
                    default: state_d = IDLE;   // unknown opcodes retire silently
                endcase
            end
            REQ:  if (bus.dmem_gnt) state_d = (kind_q == K_LOAD) ? WAIT : IDLE;
            WAIT: if (bus.dmem_rvalid) begin
                lmd_d   = bus.dmem_rdata;
                state_d = WB;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kind_q  <= K_NONE;
            ir_q    <= '0;
            alu_q   <= '0;
            b_q     <= '0;
            lmd_q   <= '0;
            rdw_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            ir_q    <= ir_d;
            alu_q   <= alu_d;
            b_q     <= b_d;
            lmd_q   <= lmd_d;
            rdw_q   <= rdw_d;
        end
    end

    assign bus.ex_ready   = (state_q == IDLE);
    assign bus.dmem_req   = (state_q == REQ);
    assign bus.dmem_we    = (state_q == REQ) && (kind_q == K_STORE);
    assign bus.dmem_addr  = alu_q;
    assign bus.dmem_wdata = b_q;
    assign bus.LMD        = lmd_q;
    assign bus.rd_w       = rdw_q;
    // r0 is hardwired; the FSM still spends its WB cycle
    assign bus.wb_en      = (state_q == WB) && (rdw_q != 5'd0);

`ifdef WB_FWD_EN
    assign bus.fwd_busy = ((kind_q == K_LOAD) && (state_q != IDLE)) ||
                          ((kind_q == K_ALU)  && (state_q == WB));
    assign bus.fwd_rd   = ir_q[25:21];
    assign bus.fwd_data = lmd_q;
`endif

    logic unused_ir;
    assign unused_ir = ^ir_q;
endmodule
